// File: rtl/multiplicador_4b_if.sv
// Button/display bundle for the interactive multiplier.
//   up, down, ok : active-low push-buttons (driven by the board/master side)
//   leds         : N-bit registered display value
//   done         : high while the product is on display
interface multiplicador_4b_if #(
  parameter int N = 4
);
  logic         up;
  logic         down;
  logic         ok;
  logic [N-1:0] leds;
  logic         done;

  modport master (output up, down, ok, input leds, done);
  modport slave  (input up, down, ok, output leds, done);
endinterface

// File: rtl/multiplicador_4b.sv
// Interactive N-bit multiplier: operand A then B are edited with up/down
// buttons and confirmed with ok. A shift-add engine then forms the 2N-bit
// product in N cycles, and the product is shown as a high nibble, then a
// low nibble.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : synchronous reset, active-high
//   bus  : slave side of multiplicador_4b_if (buttons in, leds/done out)
module multiplicador_4b #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  multiplicador_4b_if.slave   bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CALC = 3'd2,
    S_HI   = 3'd3,
    S_LO   = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [N-1:0]    a, a_n, b, b_n;
  logic [2*N-1:0]  acc, acc_n, mcand, mcand_n, product, product_n, sum;
  logic [N-1:0]    mplier, mplier_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    leds, leds_n;
  logic            done, done_n;

  // Button conditioning: buttons are active-low; an event fires only on the
  // first cycle a press is seen, so a long hold counts once.
  logic up_p, dn_p, ok_p;
  logic up_prev, dn_prev, ok_prev;
  logic up_ev, dn_ev, ok_ev;

  assign up_p  = ~bus.up;
  assign dn_p  = ~bus.down;
  assign ok_p  = ~bus.ok;
  assign up_ev = up_p & ~up_prev;
  assign dn_ev = dn_p & ~dn_prev;
  assign ok_ev = ok_p & ~ok_prev;

  assign bus.leds = leds;
  assign bus.done = done;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Loading prev with the live press keeps a button held across reset
      // release from producing an event.
      up_prev <= up_p;
      dn_prev <= dn_p;
      ok_prev <= ok_p;
      state   <= S_A;
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      leds    <= '0;
      done    <= 1'b0;
    end else begin
      up_prev <= up_p;
      dn_prev <= dn_p;
      ok_prev <= ok_p;
      state   <= state_n;
      a       <= a_n;
      b       <= b_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      cnt     <= cnt_n;
      product <= product_n;
      leds    <= leds_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    a_n       = a;
    b_n       = b;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    cnt_n     = cnt;
    product_n = product;
    sum       = mplier[0] ? acc + mcand : acc;

    case (state)
      S_A: begin
        // ok wins over up/down; simultaneous up+down cancel out.
        if (ok_ev)               state_n = S_B;
        else if (up_ev & ~dn_ev) a_n = a + N'(1);
        else if (dn_ev & ~up_ev) a_n = a - N'(1);
      end
      S_B: begin
        if (ok_ev) begin
          state_n  = S_CALC;
          acc_n    = '0;
          mcand_n  = {{N{1'b0}}, a};
          mplier_n = b;
          cnt_n    = '0;
        end
        else if (up_ev & ~dn_ev) b_n = b + N'(1);
        else if (dn_ev & ~up_ev) b_n = b - N'(1);
      end
      S_CALC: begin
        acc_n    = sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          product_n = sum;
          state_n   = S_HI;
        end
      end
      S_HI: if (ok_ev) state_n = S_LO;
      S_LO: if (ok_ev) state_n = S_A;
      default: state_n = S_A;
    endcase

    // Display follows the state being entered so it updates on the same edge.
    case (state_n)
      S_A:     leds_n = a_n;
      S_B:     leds_n = b_n;
      S_HI:    leds_n = product_n[2*N-1:N];
      S_LO:    leds_n = product_n[N-1:0];
      default: leds_n = '0;
    endcase
    done_n = (state_n == S_HI) || (state_n == S_LO);
  end

endmodule

// File: tb/tb_multiplicador_4b.sv
module tb_multiplicador_4b;

  typedef struct {
    bit       r;     // reset
    bit       u;     // up pressed
    bit       d;     // down pressed
    bit       o;     // ok pressed
    bit [3:0] leds;  // expected leds after the edge
    bit       done;  // expected done after the edge
  } vec_t;

  typedef struct {
    bit [3:0] leds;
    bit       done;
    int       idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  multiplicador_4b_if #(.N(4)) bus ();

  multiplicador_4b #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  bit   run_done = 1'b0;

  function automatic void add(bit r, bit u, bit d, bit o, bit [3:0] l, bit dn);
    vec_t v;
    v.r = r; v.u = u; v.d = d; v.o = o; v.leds = l; v.done = dn;
    vecs.push_back(v);
  endfunction

  // One press followed by a release; display must hold across the release.
  function automatic void press(bit u, bit d, bit o, bit [3:0] l, bit dn);
    add(1'b0, u, d, o, l, dn);
    add(1'b0, 1'b0, 1'b0, 1'b0, l, dn);
  endfunction

  // ok in S_B, then N=4 cycles of CALC; high nibble appears on the 4th edge.
  function automatic void calc(bit [3:0] hi);
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, hi, 1'b1);
  endfunction

  initial begin
    #200000;
    if (!run_done) begin
      n_fail++;
      $display("FAIL timeout: vector run did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    bus.up = 1'b1; bus.down = 1'b1; bus.ok = 1'b1;

    // Dedicated reset-state check
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.leds !== 4'h0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: leds=%b done=%b, expected leds=0000 done=0",
               bus.leds, bus.done);
    end

    // Reset state; ok held through reset release must not advance.
    add(1, 0, 0, 0, 4'h0, 0);
    add(1, 0, 0, 0, 4'h0, 0);
    add(1, 0, 0, 1, 4'h0, 0);
    add(0, 0, 0, 1, 4'h0, 0);
    add(0, 0, 0, 1, 4'h0, 0);
    add(0, 0, 0, 0, 4'h0, 0);
    press(1, 0, 0, 4'h1, 0);        // still S_A: a=1
    press(0, 0, 1, 4'h0, 0);        // S_B: b=0
    press(1, 0, 0, 4'h1, 0);        // b=1 (would be 0 if already in CALC)
    add(1, 0, 0, 0, 4'h0, 0);

    // 3 x 5 = 0x0F
    for (int i = 1; i <= 3; i++) press(1, 0, 0, 4'(i), 0);
    press(0, 0, 1, 4'h0, 0);
    for (int i = 1; i <= 5; i++) press(1, 0, 0, 4'(i), 0);
    calc(4'h0);
    press(0, 0, 1, 4'hF, 1);
    press(0, 0, 1, 4'h3, 0);

    // Wrap and maximum product 15 x 15 = 0xE1
    add(1, 0, 0, 0, 4'h0, 0);
    press(0, 1, 0, 4'hF, 0);
    press(0, 0, 1, 4'h0, 0);
    press(0, 1, 0, 4'hF, 0);
    calc(4'hE);
    press(0, 0, 1, 4'h1, 1);
    press(0, 0, 1, 4'hF, 0);
    press(1, 0, 0, 4'h0, 0);        // 15 -> 0

    // Long ok hold = one transition; up+down together cancel
    for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 4'hF, 0);
    add(0, 0, 0, 0, 4'hF, 0);
    press(1, 1, 0, 4'hF, 0);
    calc(4'h0);
    press(0, 0, 1, 4'h0, 1);
    press(0, 0, 1, 4'h0, 0);
    // ok+up together in S_A: advance, a stays 0 (product 0, not 15)
    press(1, 0, 1, 4'hF, 0);
    calc(4'h0);
    press(0, 0, 1, 4'h0, 1);
    press(0, 0, 1, 4'h0, 0);
    press(1, 1, 0, 4'h0, 0);

    // 7 x 0
    add(1, 0, 0, 0, 4'h0, 0);
    for (int i = 1; i <= 7; i++) press(1, 0, 0, 4'(i), 0);
    press(0, 0, 1, 4'h0, 0);
    calc(4'h0);
    press(0, 0, 1, 4'h0, 1);
    press(0, 0, 1, 4'h7, 0);
    // 0 x 9
    add(1, 0, 0, 0, 4'h0, 0);
    press(0, 0, 1, 4'h0, 0);
    for (int i = 1; i <= 9; i++) press(1, 0, 0, 4'(i), 0);
    calc(4'h0);
    press(0, 0, 1, 4'h0, 1);
    press(0, 0, 1, 4'h0, 0);
    // 1 x 1 (b counted down from 9, operands retained across re-edit)
    press(1, 0, 0, 4'h1, 0);
    press(0, 0, 1, 4'h9, 0);
    for (int i = 8; i >= 1; i--) press(0, 1, 0, 4'(i), 0);
    calc(4'h0);
    press(0, 0, 1, 4'h1, 1);
    press(0, 0, 1, 4'h1, 0);

    // Buttons during CALC are ignored; S_HI on schedule
    press(0, 0, 1, 4'h1, 0);
    add(0, 0, 0, 1, 4'h0, 0);
    add(0, 0, 0, 0, 4'h0, 0);
    add(0, 1, 0, 1, 4'h0, 0);
    add(0, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 0, 4'h0, 1);
    press(0, 0, 1, 4'h1, 1);
    press(0, 0, 1, 4'h1, 0);

    // Reset in the 2nd CALC cycle aborts to S_A with a=b=0
    press(0, 0, 1, 4'h1, 0);
    add(0, 0, 0, 1, 4'h0, 0);
    add(0, 0, 0, 0, 4'h0, 0);
    add(1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 0, 4'h0, 0);
    press(0, 0, 1, 4'h0, 0);        // S_B, b=0
    calc(4'h0);
    press(0, 0, 1, 4'h0, 1);        // a=0 -> product 0

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      rst     = vecs[i].r;
      bus.up   = ~vecs[i].u;
      bus.down = ~vecs[i].d;
      bus.ok   = ~vecs[i].o;
      e.leds = vecs[i].leds; e.done = vecs[i].done; e.idx = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_tests++;
      if (bus.leds !== e.leds || bus.done !== e.done) begin
        n_fail++;
        $display("FAIL vec%0d: leds=%b done=%b, expected leds=%b done=%b",
                 e.idx, bus.leds, bus.done, e.leds, e.done);
      end
    end

    run_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplicador_4b.md
Name: multiplicador_4b

Overview:
- Interactive 4-bit multiplier. It is the inverse-operation companion to the team's push-button divider board block.
- The user enters operand A, then operand B, with up/down buttons and confirms each with ok.
- A sequential shift-add engine computes the 8-bit product in N cycles.
- The product is shown on the 4 leds as a high nibble, then a low nibble.

Parameters:
N, 4, operand width; leds width = N; product width = 2N (only N=4 is verified)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
up  input  1  push-button, active-low; increments the operand being edited
down  input  1  push-button, active-low; decrements the operand being edited
ok  input  1  push-button, active-low; advances the step sequence
leds  output  N  displayed value, registered
done  output  1  high while the product is displayed, registered

Behaviour:
- Button conditioning
  - Internal press signals: up_p = ~up, dn_p = ~down, ok_p = ~ok.
  - Each press signal has a prev register.
  - Event = press & ~prev, so there is exactly one event per press regardless of hold length.
  - During rst, prev <= press. A button held through reset release produces no event.
- States: S_A, S_B, S_CALC, S_HI, S_LO.
- Reset (sync, active-high, overrides everything, including mid-CALC): state=S_A, a=0, b=0, product=0, leds=0, done=0.
- S_A: editing A.
  - up event: a=a+1 mod 2^N (15->0).
  - down event: a=a-1 mod 2^N (0->15).
  - up and down events in the same cycle: a unchanged.
  - ok event: go to S_B. ok has priority, so up/down events in that cycle are ignored.
- S_B: identical to S_A, but the operand is b.
  - ok event: go to S_CALC and load acc=0, mcand={0,a} (2N bits), mplier=b, cnt=0.
- S_CALC: lasts exactly N cycles. Each cycle:
  - if mplier[0], acc=acc+mcand (2N-bit, no overflow is possible);
  - mcand<<=1, mplier>>=1, cnt++.
  - On the N-th cycle: product=final acc, go to S_HI.
  - All button events are ignored in S_CALC.
- S_HI: ok event -> S_LO; up/down ignored.
- S_LO: ok event -> S_A. a and b are retained for re-edit; product is retained until the next S_CALC load.
- leds (registered, reflecting the state entered):
  - S_A: a
  - S_B: b
  - S_CALC: 0
  - S_HI: product[2N-1:N]
  - S_LO: product[N-1:0]
- done: 1 in S_HI and S_LO; 0 otherwise.
- Latency
  - Button low sampled at edge k -> state/leds update at edge k.
  - ok in S_B at edge k -> S_HI with leds = product high nibble at edge k+N.

Test Plan:
1. Assert rst 2 cycles with all buttons high (released) -> leds=0000, done=0, state S_A. Hold ok low through the rst release -> no transition.
2. A = 3 ups; ok; B = 5 ups; ok -> leds 0011, then 0000, then 0101, then 0000 for 4 cycles. Then done=1, leds=0000 (15 high nibble); ok -> leds=1111; ok -> S_A, leds=0011.
3. Wrap and maximum product:
   - One down in S_A -> a=1111; same for b -> ok -> 225=0xE1.
   - Display shows leds=1110, then 0001.
   - up in S_A with a=15 -> a=0000.
4. Hold ok low for 10 cycles in S_A -> exactly one transition, to S_B. up and down low on the same edge -> operand unchanged. ok and up on the same edge in S_A -> S_B, a unchanged.
5. a=7, b=0 -> product 0x00 (both nibbles 0000). a=0, b=9 -> 0x00. a=1, b=1 -> 0x01.
6. Press ok and up during S_CALC -> ignored, S_HI reached on schedule. Assert rst in the 2nd S_CALC cycle -> next edge: S_A, leds=0000, done=0, a=b=0.
